ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the 8x8 single-port RAM and drives its en/rw/address/data_in ports.
- Turns a push/pop request stream into RAM write/read cycles.
- Consumes the RAM's registered data_out and returns it as pop data with a valid strobe.
- Owns pointers, occupancy and full/empty status; the RAM holds storage only.

---
 rtl/ram_fifo_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module   : ram_fifo_ctrl
// Purpose  : FIFO controller in front of a single-port RAM. It drives the RAM
//            port and keeps the FIFO pointers, occupancy and full/empty flags.
//            Optional sticky ovf/udf flags are enabled by RAM_FIFO_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
`ifdef RAM_FIFO_ERR_FLAGS_EN
    output logic          ovf,
    output logic          udf,
`endif
    output logic          ram_en,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(1) << AW;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_pop_valid;

    logic          w_pop_ready;
    logic          w_push_ready;
    logic [AW:0]   w_count_nxt;

    // One RAM op per cycle: pop wins, and nothing is accepted while in reset.
    assign w_pop_ready  = pop  & ~r_empty & ~rst;
    assign w_push_ready = push & ~r_full  & ~w_pop_ready & ~rst;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ready)
            w_count_nxt = r_count + (AW+1)'(1);
        else if (w_pop_ready)
            w_count_nxt = r_count - (AW+1)'(1);
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_rw   = 1'b1;
        ram_addr = '0;
        ram_din  = '0;
        if (w_pop_ready) begin
            ram_en   = 1'b1;
            ram_rw   = 1'b1;
            ram_addr = r_rd_ptr;
        end else if (w_push_ready) begin
            ram_en   = 1'b1;
            ram_rw   = 1'b0;
            ram_addr = r_wr_ptr;
            ram_din  = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_pop_valid <= 1'b0;
        end else begin
            if (w_push_ready)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ready)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_DEPTH);
            r_empty     <= (w_count_nxt == '0);
            r_pop_valid <= w_pop_ready;
        end
    end

`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (push & r_full)
                r_ovf <= 1'b1;
            if (pop & r_empty)
                r_udf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

    assign push_ready = w_push_ready;
    assign pop_ready  = w_pop_ready;
    assign pop_data   = ram_dout;
    assign pop_valid  = r_pop_valid;
    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Purpose  : Directed self-checking bench for ram_fifo_ctrl with an 8x8 RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ram_en;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic          ovf;
    logic          udf;
`endif

    int n_cmp;
    int n_fail;

    ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_ready(push_ready),
        .pop       (pop),
        .pop_ready (pop_ready),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
`ifdef RAM_FIFO_ERR_FLAGS_EN
        .ovf       (ovf),
        .udf       (udf),
`endif
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered data_out held between reads.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial ram_dout = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (!ram_rw) mem[ram_addr] <= ram_din;
            else         ram_dout      <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'hAA;
        #1;
        n_cmp++; if (push_ready !== 1'b0 || pop_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_gating: push_ready=%b pop_ready=%b ram_en=%b want 0 0 0", push_ready, pop_ready, ram_en); end
        step(); step();
        push = 1'b0; pop = 1'b0; rst = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: count=%0d empty=%b full=%b pop_valid=%b want 0 1 0 0", count, empty, full, pop_valid); end
        n_cmp++; if (ram_en !== 1'b0 || ram_rw !== 1'b1 || ram_addr !== 3'd0 || ram_din !== 8'd0) begin
            n_fail++; $display("FAIL idle_drive: en=%b rw=%b addr=%0d din=%0d want 0 1 0 0", ram_en, ram_rw, ram_addr, ram_din); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(20 + i);
            #1;
            n_cmp++; if (push_ready !== 1'b1 || ram_en !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 3'(i) || ram_din !== 8'(20 + i)) begin
                n_fail++; $display("FAIL fill_write[%0d]: ready=%b en=%b rw=%b addr=%0d din=%0d want 1 1 0 %0d %0d", i, push_ready, ram_en, ram_rw, ram_addr, ram_din, i, 20 + i); end
            step();
        end
        push = 1'b0;
        #1;
        n_cmp++; if (full !== 1'b1 || count !== 4'd8 || empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_status: full=%b count=%0d empty=%b want 1 8 0", full, count, empty); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            #1;
            n_cmp++; if (pop_ready !== 1'b1 || ram_en !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 3'(i)) begin
                n_fail++; $display("FAIL drain_read[%0d]: ready=%b en=%b rw=%b addr=%0d want 1 1 1 %0d", i, pop_ready, ram_en, ram_rw, ram_addr, i); end
            step();
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'(20 + i)) begin
                n_fail++; $display("FAIL drain_data[%0d]: valid=%b data=%0d want 1 %0d", i, pop_valid, pop_data, 20 + i); end
        end
        pop = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL drain_status: empty=%b count=%0d full=%b want 1 0 0", empty, count, full); end
        step();
        n_cmp++; if (pop_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid_drop: pop_valid=%b want 0", pop_valid); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'(20 + i); step();
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1; step();
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'(20 + i)) begin
                n_fail++; $display("FAIL wrap_pre_pop[%0d]: valid=%b data=%0d want 1 %0d", i, pop_valid, pop_data, 20 + i); end
        end
        pop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(30 + i);
            #1;
            n_cmp++; if (push_ready !== 1'b1 || ram_addr !== 3'((3 + i) % 8)) begin
                n_fail++; $display("FAIL wrap_waddr[%0d]: ready=%b addr=%0d want 1 %0d", i, push_ready, ram_addr, (3 + i) % 8); end
            step();
        end
        push = 1'b0;
        #1;
        n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin
            n_fail++; $display("FAIL wrap_full: full=%b count=%0d want 1 8", full, count); end
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1; step();
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'(30 + i)) begin
                n_fail++; $display("FAIL wrap_pop[%0d]: valid=%b data=%0d want 1 %0d", i, pop_valid, pop_data, 30 + i); end
        end
        pop = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        push = 1'b1; push_data = 8'd50; step();
        push_data = 8'd51; step();
        push_data = 8'd40; pop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (pop_ready !== 1'b1 || push_ready !== 1'b0 || ram_rw !== 1'b1 || ram_addr !== 3'(3 + i)) begin
                n_fail++; $display("FAIL prio_pop[%0d]: pop_ready=%b push_ready=%b rw=%b addr=%0d want 1 0 1 %0d", i, pop_ready, push_ready, ram_rw, ram_addr, 3 + i); end
            step();
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'(50 + i)) begin
                n_fail++; $display("FAIL prio_data[%0d]: valid=%b data=%0d want 1 %0d", i, pop_valid, pop_data, 50 + i); end
        end
        #1;
        n_cmp++; if (pop_ready !== 1'b0 || push_ready !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 3'd5 || ram_din !== 8'd40) begin
            n_fail++; $display("FAIL prio_empty_push: pop_ready=%b push_ready=%b rw=%b addr=%0d din=%0d want 0 1 0 5 40", pop_ready, push_ready, ram_rw, ram_addr, ram_din); end
        step();
        push = 1'b0; pop = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd1 || empty !== 1'b0 || pop_valid !== 1'b0) begin
            n_fail++; $display("FAIL prio_count: count=%0d empty=%b pop_valid=%b want 1 0 0", count, empty, pop_valid); end
        pop = 1'b1; step(); pop = 1'b0;
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'd40 || count !== 4'd0) begin
            n_fail++; $display("FAIL prio_late_data: valid=%b data=%0d count=%0d want 1 40 0", pop_valid, pop_data, count); end
    endtask

    task automatic test_boundary();
        pop = 1'b1;
        #1;
        n_cmp++; if (pop_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL udf_gate: pop_ready=%b ram_en=%b want 0 0", pop_ready, ram_en); end
        step(); pop = 1'b0;
        n_cmp++; if (pop_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL udf_state: pop_valid=%b count=%0d empty=%b want 0 0 1", pop_valid, count, empty); end
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(60 + i); step();
        end
        push_data = 8'hEE;
        #1;
        n_cmp++; if (push_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL ovf_gate: push_ready=%b ram_en=%b want 0 0", push_ready, ram_en); end
        step(); push = 1'b0;
        n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state: count=%0d full=%b want 8 1", count, full); end
`ifdef RAM_FIFO_ERR_FLAGS_EN
        n_cmp++; if (ovf !== 1'b1 || udf !== 1'b1) begin
            n_fail++; $display("FAIL err_flags_set: ovf=%b udf=%b want 1 1", ovf, udf); end
`endif
    endtask

    task automatic test_pop_reset();
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; step();
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'(60 + i)) begin
                n_fail++; $display("FAIL prerst_pop[%0d]: valid=%b data=%0d want 1 %0d", i, pop_valid, pop_data, 60 + i); end
        end
        n_cmp++; if (count !== 4'd4) begin
            n_fail++; $display("FAIL prerst_count: count=%0d want 4", count); end
        step();
        rst = 1'b1; push = 1'b1; push_data = 8'h77;
        #1;
        n_cmp++; if (pop_ready !== 1'b0 || push_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_gate: pop_ready=%b push_ready=%b ram_en=%b want 0 0 0", pop_ready, push_ready, ram_en); end
        step();
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        #1;
        n_cmp++; if (pop_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL rst_after_pop: pop_valid=%b count=%0d empty=%b full=%b want 0 0 1 0", pop_valid, count, empty, full); end
`ifdef RAM_FIFO_ERR_FLAGS_EN
        n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin
            n_fail++; $display("FAIL err_flags_clear: ovf=%b udf=%b want 0 0", ovf, udf); end
`endif
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_boundary();
        test_pop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
